// File: rtl/y_seq_adder.sv
// y_seq_adder: digit-serial adder, DIGIT bits per cycle, registered sum/carry/overflow.
// Define Y_SEQ_ADDER_SUB_EN to add a sub port selecting a - b.
module y_seq_adder #(
    parameter int WIDTH = 32,
    parameter int DIGIT = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
`ifdef Y_SEQ_ADDER_SUB_EN
    input  logic             sub,
`endif
    output logic [WIDTH-1:0] z,
    output logic             cout,
    output logic             ovf,
    output logic             busy,
    output logic             done
);
    localparam int NDIG = WIDTH / DIGIT;
    localparam int KW = (NDIG > 1) ? $clog2(NDIG) : 1;
    typedef enum logic [1:0] {IDLE, ADD, DONE} state_t;
    state_t state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d, z_q, z_d;
    logic [KW-1:0] k_q, k_d;
    logic carry_q, carry_d, cout_q, cout_d, ovf_q, ovf_d;
    logic [DIGIT-1:0] a_dig, b_dig;
    logic [DIGIT:0] sum;
    logic sub_in, last;
`ifdef Y_SEQ_ADDER_SUB_EN
    assign sub_in = sub;
`else
    assign sub_in = 1'b0;
`endif
    // Subtraction is folded in at latch time as a + ~b + 1.
    always_comb begin
        state_d = state_q;
        a_d = a_q;
        b_d = b_q;
        z_d = z_q;
        k_d = k_q;
        carry_d = carry_q;
        cout_d = cout_q;
        ovf_d = ovf_q;
        a_dig = a_q[k_q*DIGIT +: DIGIT];
        b_dig = b_q[k_q*DIGIT +: DIGIT];
        sum = {1'b0, a_dig} + {1'b0, b_dig} + {{DIGIT{1'b0}}, carry_q};
        last = (k_q == KW'(NDIG - 1));
        case (state_q)
            IDLE: if (start) begin
                a_d = a;
                b_d = sub_in ? ~b : b;
                carry_d = sub_in | cin;
                k_d = '0;
                state_d = ADD;
            end
            ADD: begin
                z_d[k_q*DIGIT +: DIGIT] = sum[DIGIT-1:0];
                carry_d = sum[DIGIT];
                k_d = last ? '0 : k_q + 1'b1;
                if (last) begin
                    cout_d = sum[DIGIT];
                    // carry into MSB recovered as sum_msb ^ a_msb ^ b_msb
                    ovf_d = sum[DIGIT] ^ sum[DIGIT-1] ^ a_dig[DIGIT-1] ^ b_dig[DIGIT-1];
                    state_d = DONE;
                end
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            a_q <= '0;
            b_q <= '0;
            z_q <= '0;
            k_q <= '0;
            carry_q <= 1'b0;
            cout_q <= 1'b0;
            ovf_q <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q <= a_d;
            b_q <= b_d;
            z_q <= z_d;
            k_q <= k_d;
            carry_q <= carry_d;
            cout_q <= cout_d;
            ovf_q <= ovf_d;
        end
    end
    assign z = z_q;
    assign cout = cout_q;
    assign ovf = ovf_q;
    assign busy = (state_q == ADD);
    assign done = (state_q == DONE);
endmodule

// File: tb/tb_y_seq_adder.sv
// tb_y_seq_adder: random and directed scoreboard bench for y_seq_adder against an arithmetic model.
module tb_y_seq_adder;
    localparam int W = 32;
    localparam int LAT = 5;
`ifdef Y_SEQ_ADDER_SUB_EN
    localparam bit HAS_SUB = 1'b1;
`else
    localparam bit HAS_SUB = 1'b0;
`endif
    logic clk = 0, reset = 0, start = 0, cin = 0, sub = 0;
    logic [W-1:0] a = '0, b = '0, z;
    logic cout, ovf, busy, done;
    logic start8 = 0, cin8 = 0, cout8, ovf8, busy8, done8;
    logic [7:0] a8 = '0, b8 = '0, z8;
    int total = 0, bad = 0, cyc = 0;
    typedef struct {
        logic [W-1:0] z;
        logic c;
        logic v;
        int t0;
    } exp_t;
    exp_t sbq[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    y_seq_adder #(.WIDTH(W), .DIGIT(8)) dut (
        .clk(clk), .reset(reset), .start(start), .a(a), .b(b), .cin(cin),
`ifdef Y_SEQ_ADDER_SUB_EN
        .sub(sub),
`endif
        .z(z), .cout(cout), .ovf(ovf), .busy(busy), .done(done)
    );

    y_seq_adder #(.WIDTH(8), .DIGIT(8)) dut8 (
        .clk(clk), .reset(reset), .start(start8), .a(a8), .b(b8), .cin(cin8),
`ifdef Y_SEQ_ADDER_SUB_EN
        .sub(1'b0),
`endif
        .z(z8), .cout(cout8), .ovf(ovf8), .busy(busy8), .done(done8)
    );

    task automatic chk(input string n, input logic [63:0] act, input logic [63:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h", n, act, want);
        end
    endtask

    function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y,
                                   input logic ci, input logic sb, input int t);
        exp_t e;
        longint sx, sy, sr;
        longint unsigned ur;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        sr = sb ? sx - sy : sx + sy + longint'(ci);
        ur = longint'(x) + longint'(y) + longint'(ci);
        e.z = sr[W-1:0];
        e.c = sb ? (x >= y) : ur[W];
        e.v = (sr != longint'($signed(sr[W-1:0])));
        e.t0 = t;
        return e;
    endfunction

    task automatic issue(input logic [W-1:0] x, input logic [W-1:0] y, input logic ci, input logic sb);
        int n = 0;
        @(negedge clk);
        while ((busy || done) && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) begin
            total++;
            bad++;
            $display("FAIL idle_timeout busy=%0b done=%0b", busy, done);
        end
        a = x; b = y; cin = ci; sub = sb & HAS_SUB; start = 1;
        @(posedge clk);
        #1;
        sbq.push_back(model(x, y, ci, sb & HAS_SUB, cyc));
        start = 0; a = $urandom; b = $urandom; cin = 1'($urandom); sub = 1'($urandom) & HAS_SUB;
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (done) begin
            if (sbq.size() == 0) begin
                total++;
                bad++;
                $display("FAIL spurious_done z=%0h", z);
            end else begin
                e = sbq.pop_front();
                chk("z", z, e.z);
                chk("cout", cout, e.c);
                chk("ovf", ovf, e.v);
                chk("latency", cyc + 1 - e.t0, LAT);
                chk("busy_in_done", busy, 0);
            end
        end
    end

    initial begin
        int nb, n, t;
        #1 reset = 1; start = 1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_z", z, 0);
        chk("rst_cout", cout, 0);
        chk("rst_ovf", ovf, 0);
        @(negedge clk); reset = 0; start = 0;
        issue(32'hFFFFFFFF, 32'h1, 0, 0);
        issue(32'h7FFFFFFF, 32'h1, 0, 0);
        issue(32'h80000000, 32'h80000000, 0, 0);
        issue(32'hFFFFFFFF, 32'hFFFFFFFF, 1, 0);
        issue(32'h0, 32'h0, 1, 0);
        issue(32'h000000FF, 32'h00000001, 0, 0);
`ifdef Y_SEQ_ADDER_SUB_EN
        issue(32'd5, 32'd7, 1, 1);
        issue(32'd7, 32'd5, 0, 1);
        issue(32'h80000000, 32'h1, 0, 1);
`endif
        issue(32'd1, 32'd2, 1, 0);
        start = 1; a = 32'h10; b = 32'h10; cin = 0;
        nb = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            nb += int'(busy);
        end
        @(posedge clk);
        #1 start = 0;
        chk("busy_cycles", nb, 4);
        nb = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            nb += int'(busy);
        end
        chk("no_restart_in_done", nb, 0);
        issue($urandom | 32'h1, $urandom, 0, 0);
        @(posedge clk);
        #2 reset = 1;
        #1;
        sbq.delete();
        chk("midrst_busy", busy, 0);
        chk("midrst_done", done, 0);
        chk("midrst_z", z, 0);
        chk("midrst_cout", cout, 0);
        @(negedge clk); start = 1;
        @(negedge clk); reset = 0; start = 0;
        repeat (8) @(negedge clk);
        issue(32'd3, 32'd4, 0, 0);
        for (int i = 0; i < 40; i++) begin
            case (i % 4)
                0: issue($urandom, $urandom, 1'($urandom), 1'($urandom));
                1: issue(32'h7FFFFFFF ^ ($urandom & 32'h3), $urandom & 32'h3, 1'($urandom), 1'($urandom));
                2: issue(32'h80000000 | ($urandom & 32'hF), 32'h80000000 | ($urandom & 32'hF), 1'($urandom), 1'($urandom));
                default: issue($urandom, ~($urandom & 32'h1), 1'($urandom), 1'($urandom));
            endcase
        end
        n = 0;
        while (sbq.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("drain", sbq.size(), 0);
        @(negedge clk); a8 = 8'hC8; b8 = 8'h64; cin8 = 1; start8 = 1;
        @(posedge clk);
        #1 start8 = 0; t = cyc; n = 0;
        while (!done8 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("w8_latency", cyc + 1 - t, 2);
        chk("w8_z", z8, 8'h2D);
        chk("w8_cout", cout8, 1);
        chk("w8_ovf", ovf8, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/y_seq_adder.md
Y_SEQ_ADDER -- requirements
Module: y_seq_adder

Interface
REQ-001 Parameter WIDTH, default 32, operand and result width in bits.
REQ-002 Parameter DIGIT, default 8, bits added per cycle; WIDTH SHALL be an integer multiple of DIGIT, and DIGIT SHALL be at least 1.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 start  input  1  request a new addition; sampled on rising edge.
REQ-006 a  input  WIDTH  first operand.
REQ-007 b  input  WIDTH  second operand.
REQ-008 cin  input  1  carry into bit 0.
REQ-009 z  output  WIDTH  registered sum.
REQ-010 cout  output  1  registered carry out of bit WIDTH-1.
REQ-011 ovf  output  1  registered two's-complement overflow.
REQ-012 busy  output  1  high while an addition is in progress.
REQ-013 done  output  1  one-cycle pulse when z, cout and ovf become valid.

Function
REQ-014 States SHALL be IDLE, ADD and DONE; reset enters IDLE.
REQ-015 IDLE with start=1: latch a, b and cin, clear the digit counter, and go to ADD.
REQ-016 Each ADD cycle: add digit k of the latched operands plus the running carry, write the result into z[k*DIGIT +: DIGIT], keep the carry, and increment k.
REQ-017 After digit WIDTH/DIGIT-1: set cout to the final carry, set ovf to (carry into MSB) XOR (carry out of MSB), and go to DONE.
REQ-018 DONE lasts exactly one cycle with done=1, then returns to IDLE.
REQ-019 Latency: done SHALL assert WIDTH/DIGIT+1 rising edges after the edge that accepted start.
REQ-020 busy SHALL be 1 in ADD and 0 in IDLE and DONE.
REQ-021 start SHALL be ignored in ADD; changes to a, b or cin after acceptance SHALL NOT affect the result.
REQ-022 start=1 during DONE SHALL be ignored; a new start is accepted only in IDLE.
REQ-023 z, cout and ovf SHALL hold their last completed values in IDLE until the next accepted start.
REQ-024 Result SHALL be bit-exact with {cout,z} = a + b + cin, computed modulo 2^(WIDTH+1).

Reset
REQ-025 Reset asserted in any state, including mid-ADD, SHALL immediately force state=IDLE, z=0, cout=0, ovf=0, busy=0, done=0, and counter=0.
REQ-026 While reset is high, start SHALL be ignored; the first start sampled after reset deasserts SHALL be accepted normally.

Configuration
REQ-027 Macro Y_SEQ_ADDER_SUB_EN: when defined, input port sub (1 bit) SHALL exist and be latched with the operands at start.
REQ-028 With Y_SEQ_ADDER_SUB_EN defined and sub=1: compute a + ~b + 1 with cin ignored; ovf uses the same MSB-carry rule; with sub=0, behaviour is as REQ-024.
REQ-029 Without Y_SEQ_ADDER_SUB_EN: no sub port exists and the block always adds per REQ-024.

Verification
REQ-030 WIDTH=32, DIGIT=8: a=0xFFFFFFFF, b=0x00000001, cin=0, start -> done exactly 5 edges later; z=0x00000000, cout=1, ovf=0.
REQ-031 a=0x7FFFFFFF, b=0x00000001, cin=0 -> z=0x80000000, cout=0, ovf=1; a=0x80000000, b=0x80000000 -> z=0, cout=1, ovf=1.
REQ-032 Start a=1, b=2, cin=1; next cycle drive start=1 with a=0x10, b=0x10 -> one done pulse only, z=0x00000004; busy stays high for 4 cycles.
REQ-033 Reset asserted on the 2nd ADD cycle -> busy=0, done=0, z=0 immediately and no done pulse; a subsequent start with a=3, b=4 gives z=7.
REQ-034 With Y_SEQ_ADDER_SUB_EN: a=5, b=7, sub=1, cin=1 -> z=0xFFFFFFFE, cout=0, ovf=0; a=7, b=5, sub=1 -> z=2, cout=1.
REQ-035 WIDTH=8, DIGIT=8: a=0xC8, b=0x64, cin=1 -> done 2 edges after start; z=0x2D, cout=1, ovf=0.
